// File: rtl/addr5_to_8_expander_if.sv
// Offset-in / address-out stream bundle for the 5-to-8 bit address expander.
// The slave side is the expander; the master side feeds offsets and consumes addresses.
interface addr5_to_8_expander_if;
  logic       in_valid;
  logic [4:0] in_addr5;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_addr8;
  logic       out_wrap;

  modport slave (
    input  in_valid,
    input  in_addr5,
    output in_ready,
    output out_valid,
    input  out_ready,
    output out_addr8,
    output out_wrap
  );

  modport master (
    output in_valid,
    output in_addr5,
    input  in_ready,
    input  out_valid,
    output out_ready,
    input  out_addr8,
    input  out_wrap
  );
endinterface

// File: rtl/addr5_to_8_expander.sv
// Rebuilds 8-bit addresses from 5-bit offsets using a page register that can auto-advance
// when the offset stream wraps; results go through a one-entry registered output stage.
module addr5_to_8_expander (
  input  logic       clk,
  input  logic       reset,
  input  logic       page_load,
  input  logic [2:0] page_in,
  input  logic       track_en,
  output logic [2:0] page,
  output logic       ovf,
  addr5_to_8_expander_if.slave bus
);

  logic [2:0] page_q, page_d;
  logic [4:0] last5_q, last5_d;
  logic       have_last_q, have_last_d;
  logic       ovf_q, ovf_d;
  logic       out_valid_q, out_valid_d;
  logic [7:0] out_addr8_q, out_addr8_d;
  logic       out_wrap_q, out_wrap_d;

  logic       in_ready;
  logic       accept;
  logic       wrap;
  logic [2:0] page_used;

  assign in_ready = !out_valid_q || bus.out_ready;
  assign accept   = bus.in_valid && in_ready;
  // An explicit load overrides wrap detection in the same cycle.
  assign wrap     = accept && track_en && have_last_q && !page_load &&
                    (bus.in_addr5 < last5_q);

  always_comb begin
    page_used = page_q;
    if (page_load) begin
      page_used = page_in;
    end else if (wrap) begin
      page_used = page_q + 3'd1;
    end
  end

  always_comb begin
    page_d      = page_q;
    last5_d     = last5_q;
    have_last_d = have_last_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    out_addr8_d = out_addr8_q;
    out_wrap_d  = out_wrap_q;

    if (page_load || accept) begin
      page_d = page_used;
    end

    if (page_load) begin
      ovf_d = 1'b0;
    end else if (wrap && (page_q == 3'd7)) begin
      ovf_d = 1'b1;
    end

    if (accept) begin
      last5_d     = bus.in_addr5;
      have_last_d = 1'b1;
      out_valid_d = 1'b1;
      out_addr8_d = {page_used, bus.in_addr5};
      out_wrap_d  = wrap;
    end else begin
      if (page_load) begin
        have_last_d = 1'b0;
      end
      // Drain leaves the data fields untouched.
      if (out_valid_q && bus.out_ready) begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      page_q      <= 3'd0;
      last5_q     <= 5'd0;
      have_last_q <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_addr8_q <= 8'h00;
      out_wrap_q  <= 1'b0;
    end else begin
      page_q      <= page_d;
      last5_q     <= last5_d;
      have_last_q <= have_last_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_addr8_q <= out_addr8_d;
      out_wrap_q  <= out_wrap_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_addr8 = out_addr8_q;
  assign bus.out_wrap  = out_wrap_q;
  assign page          = page_q;
  assign ovf           = ovf_q;

endmodule

// File: tb/tb_addr5_to_8_expander.sv
// Bench for addr5_to_8_expander: directed vector table with hand-derived results, then random
// traffic checked by a reference model whose expected outputs flow through a scoreboard queue.
module tb_addr5_to_8_expander;

  logic       clk;
  logic       reset;
  logic       page_load;
  logic [2:0] page_in;
  logic       track_en;
  logic [2:0] page;
  logic       ovf;

  addr5_to_8_expander_if bus ();

  addr5_to_8_expander dut (
    .clk       (clk),
    .reset     (reset),
    .page_load (page_load),
    .page_in   (page_in),
    .track_en  (track_en),
    .page      (page),
    .ovf       (ovf),
    .bus       (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state and scoreboard of {page_used, offset, wrap}.
  logic [2:0] m_page;
  logic [4:0] m_last;
  logic       m_hl;
  logic       m_ov;
  logic       m_ovf;
  logic [8:0] sb[$];

  typedef struct {
    logic       rst;
    logic       pl;
    logic [2:0] pin;
    logic       te;
    logic       iv;
    logic [4:0] a5;
    logic       ordy;
    logic       rdy;
    logic [2:0] pg;
    logic       of;
    logic       ov;
    logic [7:0] addr;
    logic       wr;
  } vec_t;

  vec_t vecs[22];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_page = 3'd0;
    m_last = 5'd0;
    m_hl   = 1'b0;
    m_ov   = 1'b0;
    m_ovf  = 1'b0;
    sb.delete();
  endtask

  // One clock: drive, check in_ready, advance model, then check registered state after the edge.
  task automatic cycle(input logic rst, input logic pl, input logic [2:0] pin, input logic te,
                       input logic iv, input logic [4:0] a5, input logic ordy,
                       output logic rdy_seen);
    logic       m_rdy, acc, wr;
    logic [2:0] pu;
    @(negedge clk);
    reset         = rst;
    page_load     = pl;
    page_in       = pin;
    track_en      = te;
    bus.in_valid  = iv;
    bus.in_addr5  = a5;
    bus.out_ready = ordy;
    #1;
    rdy_seen = bus.in_ready;
    m_rdy = !m_ov || ordy;
    chk("in_ready", {31'd0, bus.in_ready}, {31'd0, m_rdy});
    if (rst) begin
      model_reset();
    end else begin
      acc = iv && m_rdy;
      if (m_ov && ordy && sb.size() > 0) void'(sb.pop_front());
      wr = acc && te && m_hl && !pl && (a5 < m_last);
      pu = pl ? pin : (wr ? m_page + 3'd1 : m_page);
      if (acc) begin
        sb.push_back({pu, a5, wr});
        m_ov = 1'b1;
      end else if (ordy) begin
        m_ov = 1'b0;
      end
      if (pl) m_ovf = 1'b0;
      else if (wr && m_page == 3'd7) m_ovf = 1'b1;
      if (pl || acc) m_page = pu;
      if (acc) begin
        m_last = a5;
        m_hl   = 1'b1;
      end else if (pl) begin
        m_hl = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    chk("page", {29'd0, page}, {29'd0, m_page});
    chk("ovf", {31'd0, ovf}, {31'd0, m_ovf});
    chk("out_valid", {31'd0, bus.out_valid}, {31'd0, m_ov});
    if (m_ov) begin
      if (sb.size() == 0) begin
        chk("scoreboard_empty", 32'd0, 32'd1);
      end else begin
        chk("sb_out", {23'd0, bus.out_addr8, bus.out_wrap}, {23'd0, sb[0]});
      end
    end
  endtask

  logic rdy;

  initial begin
    //            rst pl pin te iv a5  ordy | rdy pg of ov addr   wr
    vecs[0]  = '{0, 1, 5, 0, 0, 0,  1, 1, 5, 0, 0, 8'h00, 0};
    vecs[1]  = '{0, 0, 0, 0, 1, 10, 1, 1, 5, 0, 1, 8'hAA, 0};
    vecs[2]  = '{0, 1, 2, 0, 0, 0,  1, 1, 2, 0, 0, 8'hAA, 0};
    vecs[3]  = '{0, 0, 0, 1, 1, 30, 1, 1, 2, 0, 1, 8'h5E, 0};
    vecs[4]  = '{0, 0, 0, 1, 1, 31, 1, 1, 2, 0, 1, 8'h5F, 0};
    vecs[5]  = '{0, 0, 0, 1, 1, 1,  1, 1, 3, 0, 1, 8'h61, 1};
    vecs[6]  = '{0, 1, 7, 1, 0, 0,  1, 1, 7, 0, 0, 8'h61, 1};
    vecs[7]  = '{0, 0, 0, 1, 1, 20, 1, 1, 7, 0, 1, 8'hF4, 0};
    vecs[8]  = '{0, 0, 0, 1, 1, 3,  1, 1, 0, 1, 1, 8'h03, 1};
    vecs[9]  = '{0, 1, 6, 1, 0, 0,  1, 1, 6, 0, 0, 8'h03, 1};
    vecs[10] = '{0, 0, 0, 1, 1, 12, 1, 1, 6, 0, 1, 8'hCC, 0};
    vecs[11] = '{0, 0, 0, 1, 1, 12, 1, 1, 6, 0, 1, 8'hCC, 0};
    vecs[12] = '{0, 0, 0, 0, 1, 20, 1, 1, 6, 0, 1, 8'hD4, 0};
    vecs[13] = '{0, 0, 0, 0, 1, 3,  1, 1, 6, 0, 1, 8'hC3, 0};
    vecs[14] = '{0, 0, 0, 0, 1, 5,  0, 0, 6, 0, 1, 8'hC3, 0};
    vecs[15] = '{0, 0, 0, 0, 1, 5,  0, 0, 6, 0, 1, 8'hC3, 0};
    vecs[16] = '{0, 0, 0, 0, 1, 5,  0, 0, 6, 0, 1, 8'hC3, 0};
    vecs[17] = '{0, 0, 0, 0, 1, 9,  1, 1, 6, 0, 1, 8'hC9, 0};
    vecs[18] = '{0, 1, 1, 1, 1, 25, 1, 1, 1, 0, 1, 8'h39, 0};
    vecs[19] = '{0, 1, 4, 1, 1, 2,  1, 1, 4, 0, 1, 8'h82, 0};
    vecs[20] = '{1, 0, 0, 1, 1, 7,  0, 0, 0, 0, 0, 8'h00, 0};
    vecs[21] = '{0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0, 8'h00, 0};

    reset = 1'b1;
    page_load = 1'b0;
    page_in = 3'd0;
    track_en = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_addr5 = 5'd0;
    bus.out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_page", {29'd0, page}, 32'd0);
    chk("reset_ovf", {31'd0, ovf}, 32'd0);
    chk("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("reset_out_addr8", {24'd0, bus.out_addr8}, 32'd0);
    chk("reset_out_wrap", {31'd0, bus.out_wrap}, 32'd0);
    chk("reset_in_ready", {31'd0, bus.in_ready}, 32'd1);

    for (int i = 0; i < 22; i++) begin
      cycle(vecs[i].rst, vecs[i].pl, vecs[i].pin, vecs[i].te, vecs[i].iv, vecs[i].a5,
            vecs[i].ordy, rdy);
      chk($sformatf("vec%0d_in_ready", i), {31'd0, rdy}, {31'd0, vecs[i].rdy});
      chk($sformatf("vec%0d_page", i), {29'd0, page}, {29'd0, vecs[i].pg});
      chk($sformatf("vec%0d_ovf", i), {31'd0, ovf}, {31'd0, vecs[i].of});
      chk($sformatf("vec%0d_out_valid", i), {31'd0, bus.out_valid}, {31'd0, vecs[i].ov});
      chk($sformatf("vec%0d_out", i), {23'd0, bus.out_addr8, bus.out_wrap},
          {23'd0, vecs[i].addr, vecs[i].wr});
    end

    // Random traffic; loads and resets kept rare so tracking wraps actually occur.
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 63) == 0), ($urandom_range(0, 9) == 0),
            3'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)),
            ($urandom_range(0, 3) != 0), rdy);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
